// File: rtl/dds_sweep_ctrl_if.sv
// Host/DDS-facing bundle for the FCW sweep sequencer: sweep config and request in,
// FCW and status pulses out.
interface dds_sweep_ctrl_if #(
  parameter int unsigned FCW_W   = 32,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned IDX_W   = 16
);
  logic               start;
  logic               abort;
  logic               mode;
  logic [FCW_W-1:0]   fcw_start;
  logic [FCW_W-1:0]   fcw_stop;
  logic [FCW_W-1:0]   fcw_step;
  logic [DWELL_W-1:0] dwell;
  logic [FCW_W-1:0]   fcw_out;
  logic               fcw_valid;
  logic               phase_clr;
  logic               busy;
  logic               done;
  logic               wrap;
  logic               err;
  logic [IDX_W-1:0]   step_idx;

  modport master (
    output start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    input  fcw_out, fcw_valid, phase_clr, busy, done, wrap, err, step_idx
  );

  modport slave (
    input  start, abort, mode, fcw_start, fcw_stop, fcw_step, dwell,
    output fcw_out, fcw_valid, phase_clr, busy, done, wrap, err, step_idx
  );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep sequencer: steps the FCW from start to stop with a per-step dwell,
// single-shot or continuous, with a phase-clear pulse at every sweep start.
module dds_sweep_ctrl #(
  parameter int unsigned FCW_W   = 32,
  parameter int unsigned DWELL_W = 16,
  parameter int unsigned IDX_W   = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  dds_sweep_ctrl_if.slave  bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t             r_state,   w_state;
  logic [FCW_W-1:0]   r_fcw_out, w_fcw_out;
  logic [IDX_W-1:0]   r_idx,     w_idx;
  logic [DWELL_W-1:0] r_cnt,     w_cnt;
  logic [DWELL_W-1:0] r_reload,  w_reload;
  logic [FCW_W-1:0]   r_start,   w_start;
  logic [FCW_W-1:0]   r_stop,    w_stop;
  logic [FCW_W-1:0]   r_step,    w_step;
  logic               r_mode,    w_mode;
  logic               r_busy,    w_busy;
  logic               r_valid,   w_valid;
  logic               r_pclr,    w_pclr;
  logic               r_done,    w_done;
  logic               r_wrap,    w_wrap;
  logic               r_err,     w_err;
  logic [FCW_W:0]     w_sum;
  logic [DWELL_W-1:0] w_dwell_m1;

  // State and output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_fcw_out <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_reload  <= '0;
      r_start   <= '0;
      r_stop    <= '0;
      r_step    <= '0;
      r_mode    <= 1'b0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_pclr    <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_fcw_out <= w_fcw_out;
      r_idx     <= w_idx;
      r_cnt     <= w_cnt;
      r_reload  <= w_reload;
      r_start   <= w_start;
      r_stop    <= w_stop;
      r_step    <= w_step;
      r_mode    <= w_mode;
      r_busy    <= w_busy;
      r_valid   <= w_valid;
      r_pclr    <= w_pclr;
      r_done    <= w_done;
      r_wrap    <= w_wrap;
      r_err     <= w_err;
    end
  end

  // Next-state and next-output logic; the +1 bit of w_sum catches FCW overflow for the clamp
  always_comb begin
    w_state    = r_state;
    w_fcw_out  = r_fcw_out;
    w_idx      = r_idx;
    w_cnt      = r_cnt;
    w_reload   = r_reload;
    w_start    = r_start;
    w_stop     = r_stop;
    w_step     = r_step;
    w_mode     = r_mode;
    w_busy     = r_busy;
    w_valid    = 1'b0;
    w_pclr     = 1'b0;
    w_done     = 1'b0;
    w_wrap     = 1'b0;
    w_err      = 1'b0;
    w_sum      = {1'b0, r_fcw_out} + {1'b0, r_step};
    w_dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);

    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          if ((bus.fcw_step == '0) || (bus.fcw_start > bus.fcw_stop)) begin
            w_err = 1'b1;
          end else begin
            w_state   = ST_RUN;
            w_start   = bus.fcw_start;
            w_stop    = bus.fcw_stop;
            w_step    = bus.fcw_step;
            w_mode    = bus.mode;
            w_reload  = w_dwell_m1;
            w_cnt     = w_dwell_m1;
            w_fcw_out = bus.fcw_start;
            w_idx     = '0;
            w_busy    = 1'b1;
            w_valid   = 1'b1;
            w_pclr    = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (bus.abort) begin
          w_state   = ST_IDLE;
          w_fcw_out = '0;
          w_valid   = 1'b1;
          w_busy    = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt = r_cnt - DWELL_W'(1);
        end else if (r_fcw_out < r_stop) begin
          w_fcw_out = (w_sum > {1'b0, r_stop}) ? r_stop : w_sum[FCW_W-1:0];
          w_idx     = (&r_idx) ? r_idx : r_idx + IDX_W'(1);
          w_cnt     = r_reload;
          w_valid   = 1'b1;
        end else if (!r_mode) begin
          w_state = ST_IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else begin
          w_fcw_out = r_start;
          w_idx     = '0;
          w_cnt     = r_reload;
          w_valid   = 1'b1;
          w_pclr    = 1'b1;
          w_wrap    = 1'b1;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.fcw_out   = r_fcw_out;
  assign bus.fcw_valid = r_valid;
  assign bus.phase_clr = r_pclr;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wrap      = r_wrap;
  assign bus.err       = r_err;
  assign bus.step_idx  = r_idx;

endmodule

// File: doc/dds_sweep_ctrl.md
Name: dds_sweep_ctrl

Overview:
Sequencer that drives the runtime frequency control word (FCW) of a DDS sine generator so the tone sweeps from a start frequency to a stop frequency in fixed steps. Each frequency is held for a programmable dwell. A phase-clear pulse is issued at every sweep start so the DDS output phase is repeatable. The block sits between the host/config logic and the DDS phase accumulator, and supports single-shot and continuous (repeating) sweeps.

Parameters:
FCW_W, 32, width of all frequency control words
DWELL_W, 16, width of dwell count (cycles per frequency)
IDX_W, 16, width of step index counter

Ports:
sys_clk  in  1  system clock; all logic on rising edge
sys_rst_n  in  1  reset; synchronous, active-low
start  in  1  one-cycle request to begin a sweep; sampled only when idle
abort  in  1  stop sweep immediately; higher priority than start
mode  in  1  0 = single sweep, 1 = continuous; captured at accepted start
fcw_start  in  FCW_W  first FCW; captured at accepted start
fcw_stop  in  FCW_W  last FCW; captured at accepted start
fcw_step  in  FCW_W  FCW increment; captured at accepted start
dwell  in  DWELL_W  cycles each FCW is held; 0 is treated as 1
fcw_out  out  FCW_W  FCW to DDS accumulator
fcw_valid  out  1  1-cycle pulse in the cycle fcw_out takes a new value
phase_clr  out  1  1-cycle pulse: DDS clears its phase accumulator
busy  out  1  high while a sweep is running
done  out  1  1-cycle pulse when a single sweep completes
wrap  out  1  1-cycle pulse when a continuous sweep restarts
err  out  1  1-cycle pulse when a start request is rejected
step_idx  out  IDX_W  index of the current step (0 at start); saturates at all-ones

Behaviour:
- Reset (sys_rst_n low at an edge): fcw_out=0, step_idx=0, all other outputs 0, state IDLE. This applies mid-sweep too; there is no partial completion.
- States: IDLE, RUN.
- Edge E0, IDLE with start=1 and abort=0:
  - Rejected if fcw_step==0 or fcw_start>fcw_stop: err=1 at E1, stay IDLE, fcw_out unchanged.
  - Otherwise: snapshot config, go RUN. At E1: fcw_out=fcw_start, fcw_valid=1, phase_clr=1, busy=1, step_idx=0, dwell counter = max(dwell,1)-1.
- RUN:
  - The counter decrements each cycle while nonzero.
  - At the edge where counter==0, the next action is decided:
    - If fcw_out<stop: next = fcw_out+step, computed in FCW_W+1 bits and clamped to stop if it exceeds stop or overflows. The stop value is always visited. Load fcw_out=next, fcw_valid=1, step_idx+1, reload counter.
    - If fcw_out==stop and mode=0: done=1, busy=0, go IDLE. fcw_out holds its last value.
    - If fcw_out==stop and mode=1: fcw_out=start, fcw_valid=1, phase_clr=1, wrap=1, step_idx=0, reload counter.
- Each FCW is therefore held exactly max(dwell,1) cycles.
- start while RUN is ignored (no err). Config input changes during RUN have no effect.
- abort=1 at any edge with state RUN: next cycle fcw_out=0, fcw_valid=1, busy=0, state IDLE. No done. abort in IDLE has no effect and suppresses a simultaneous start.
- Pulses (fcw_valid, phase_clr, done, wrap, err) are exactly one cycle and registered.
- Latency: start to first fcw_valid is 1 cycle; last dwell cycle to done is 1 cycle.

Test Plan:
- Basic sweep: start=100, stop=300, step=100, dwell=3, mode=0, start at E0 -> fcw_out 100 at E1 (phase_clr), 200 at E4, 300 at E7; done and busy=0 at E10; step_idx 0,1,2.
- Clamp: 100/250/100, dwell=2 -> 100, 200, 250 at E1/E3/E5; done at E7.
- Overflow: start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x100, dwell=1 -> 0xFFFFFF00 then 0xFFFFFFFF; done at E3; no wrap to small values.
- Continuous: 0/20/10, dwell=1, mode=1 -> 0,10,20,0,10; wrap and phase_clr at E4; busy stays 1; then abort -> fcw_out=0, fcw_valid=1, busy=0 next cycle, no done.
- Reject and ignore: step=0 -> err at E1, busy 0. fcw_start>fcw_stop -> err. start pulsed during RUN -> sequence unchanged. start with abort=1 in IDLE -> nothing happens.
- Sync reset at E5 of the basic sweep -> at E6 all outputs at reset values; a start issued at E6 restarts cleanly with fcw_out=100 at E7.
